// File: rtl/rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding.
package rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_STOP = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_out_buf.sv
// One-entry valid/ready holding register for received words, with overflow pulse.
module rx_out_buf #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [n-1:0] din,
  input  logic         rdy,
  output logic [n-1:0] dout,
  output logic         vld,
  output logic         ovf
);

  logic free;

  // A word leaving this cycle frees the slot for a word arriving this cycle.
  assign free = !vld || rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      vld  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      ovf <= load && !free;
      if (load && free) begin
        dout <= din;
        vld  <= 1'b1;
      end else if (rdy) begin
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, n data bits LSB first, stop bit.
// Valid/ready on pout: a word transfers on any cycle where pout_vld && pout_rdy.
module serial_frame_rx
  import rx_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         sin_vld,
  output logic [n-1:0] pout,
  output logic         pout_vld,
  input  logic         pout_rdy,
  output logic         frm_err,
  output logic         ovf
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  rx_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [n-1:0]  shreg, shreg_nx;
  logic          good, bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      frm_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      shreg   <= shreg_nx;
      frm_err <= bad;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    good     = 1'b0;
    bad      = 1'b0;
    case (state)
      RX_IDLE: begin
        if (sin_vld && !sin) begin
          state_nx = RX_DATA;
          cnt_nx   = '0;
        end
      end
      RX_DATA: begin
        // Bits arrive LSB first, so shift in from the top.
        if (sin_vld) begin
          shreg_nx = {sin, shreg[n-1:1]};
          cnt_nx   = cnt + 1'b1;
          if (cnt == LAST) state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (sin_vld) begin
          good     = sin;
          bad      = !sin;
          state_nx = RX_IDLE;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  rx_out_buf #(.n(n)) u_out_buf (
    .clk  (clk),
    .rst  (rst),
    .load (good),
    .din  (shreg),
    .rdy  (pout_rdy),
    .dout (pout),
    .vld  (pout_vld),
    .ovf  (ovf)
  );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (n=4) with a frame-level reference model.
module tb_serial_frame_rx;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sin = 1'b1;
  logic         sin_vld = 1'b0;
  logic         pout_rdy = 1'b0;
  logic [N-1:0] pout;
  logic         pout_vld;
  logic         frm_err;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_frame_rx #(.n(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .sin      (sin),
    .sin_vld  (sin_vld),
    .pout     (pout),
    .pout_vld (pout_vld),
    .pout_rdy (pout_rdy),
    .frm_err  (frm_err),
    .ovf      (ovf)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: collect strobed bits of a frame, resolve it when complete
  logic         sb_q[$];
  logic [N-1:0] m_pout = '0;
  logic         m_vld  = 1'b0;
  logic         m_ferr = 1'b0;
  logic         m_ovf  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q.delete();
      m_pout = '0;
      m_vld  = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      logic         old_vld;
      logic         loaded;
      logic [N-1:0] word;
      old_vld = m_vld;
      loaded  = 1'b0;
      m_ferr  = 1'b0;
      m_ovf   = 1'b0;
      if (sin_vld && (sb_q.size() > 0 || sin == 1'b0)) begin
        sb_q.push_back(sin);
        if (sb_q.size() == N + 2) begin
          word = '0;
          for (int i = 0; i < N; i++) word[i] = sb_q[1 + i];
          if (sb_q[N + 1]) begin
            if (!old_vld || pout_rdy) begin
              m_pout = word;
              m_vld  = 1'b1;
              loaded = 1'b1;
            end else begin
              m_ovf = 1'b1;
            end
          end else begin
            m_ferr = 1'b1;
          end
          sb_q.delete();
        end
      end
      if (old_vld && pout_rdy && !loaded) m_vld = 1'b0;
    end
  end

  // scoreboard compare, every cycle, away from the active edge
  always @(negedge clk) begin
    n_cmp += 4;
    if (pout !== m_pout) begin
      n_bad++;
      $display("FAIL cyc_pout t=%0t got %h want %h", $time, pout, m_pout);
    end
    if (pout_vld !== m_vld) begin
      n_bad++;
      $display("FAIL cyc_pout_vld t=%0t got %b want %b", $time, pout_vld, m_vld);
    end
    if (frm_err !== m_ferr) begin
      n_bad++;
      $display("FAIL cyc_frm_err t=%0t got %b want %b", $time, frm_err, m_ferr);
    end
    if (ovf !== m_ovf) begin
      n_bad++;
      $display("FAIL cyc_ovf t=%0t got %b want %b", $time, ovf, m_ovf);
    end
  end

  // driver tasks
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      sin_vld = 1'b0;
      sin     = ~sin;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic b);
    sin     = b;
    sin_vld = 1'b1;
    @(posedge clk);
    #1;
    sin_vld = 1'b0;
    sin     = 1'b1;
  endtask

  task automatic send_frame(input logic [N-1:0] w, input logic stop, input int gap,
                            input logic rdy_on_stop);
    strobe(1'b0);
    idle(gap);
    for (int i = 0; i < N; i++) begin
      strobe(w[i]);
      idle(gap);
    end
    if (rdy_on_stop) pout_rdy = 1'b1;
    strobe(stop);
    if (rdy_on_stop) pout_rdy = 1'b0;
  endtask

  initial begin
    // reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pout", 8'(pout), 8'h0);
    chk("reset_vld", 8'(pout_vld), 8'h0);
    chk("reset_err", {6'b0, frm_err, ovf}, 8'h0);
    rst = 1'b1;
    idle(2);

    // basic frame 0,1,0,1,1,1
    pout_rdy = 1'b1;
    send_frame(4'hD, 1'b1, 0, 1'b0);
    chk("basic_pout", 8'(pout), 8'h0D);
    chk("basic_vld", 8'(pout_vld), 8'h1);
    idle(1);
    chk("basic_vld_drop", 8'(pout_vld), 8'h0);
    chk("basic_pout_kept", 8'(pout), 8'h0D);

    // gapped strobes
    send_frame(4'hD, 1'b1, 3, 1'b0);
    chk("gap_pout", 8'(pout), 8'h0D);
    chk("gap_vld", 8'(pout_vld), 8'h1);
    idle(1);

    // frame error, then recovery
    send_frame(4'hC, 1'b0, 0, 1'b0);
    chk("ferr_pulse", 8'(frm_err), 8'h1);
    chk("ferr_vld", 8'(pout_vld), 8'h0);
    idle(1);
    chk("ferr_clear", 8'(frm_err), 8'h0);
    send_frame(4'hF, 1'b1, 0, 1'b0);
    chk("after_err_pout", 8'(pout), 8'h0F);
    chk("after_err_vld", 8'(pout_vld), 8'h1);
    idle(1);

    // overflow and hold
    pout_rdy = 1'b0;
    send_frame(4'h3, 1'b1, 0, 1'b0);
    chk("ovf_first_pout", 8'(pout), 8'h03);
    chk("ovf_first_vld", 8'(pout_vld), 8'h1);
    send_frame(4'hA, 1'b1, 1, 1'b0);
    chk("ovf_pulse", 8'(ovf), 8'h1);
    chk("ovf_hold_pout", 8'(pout), 8'h03);
    chk("ovf_no_ferr", 8'(frm_err), 8'h0);
    idle(1);
    chk("ovf_clear", 8'(ovf), 8'h0);
    pout_rdy = 1'b1;
    idle(1);
    chk("ovf_drain_vld", 8'(pout_vld), 8'h0);
    chk("ovf_drain_pout", 8'(pout), 8'h03);

    // simultaneous consume and load
    pout_rdy = 1'b0;
    send_frame(4'h5, 1'b1, 0, 1'b0);
    idle(2);
    chk("sim_hold_pout", 8'(pout), 8'h05);
    send_frame(4'h9, 1'b1, 0, 1'b1);
    chk("sim_pout", 8'(pout), 8'h09);
    chk("sim_vld", 8'(pout_vld), 8'h1);
    chk("sim_ovf", 8'(ovf), 8'h0);
    idle(1);

    // reset mid-frame with a word still buffered
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_pout", 8'(pout), 8'h0);
    chk("midrst_vld", 8'(pout_vld), 8'h0);
    chk("midrst_err", {6'b0, frm_err, ovf}, 8'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    pout_rdy = 1'b1;
    send_frame(4'h6, 1'b1, 0, 1'b0);
    chk("post_rst_pout", 8'(pout), 8'h06);
    chk("post_rst_vld", 8'(pout_vld), 8'h1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Serial-to-parallel frame receiver. It is the receiving end of the serial stream produced by the team's universal shift register in right-shift/serializer modes, which emit LSB first.
- Strips a start bit, assembles n data bits and checks a stop bit.
- Delivers each word through a one-entry valid/ready output buffer.
- Sits between a serial link (bit strobe supplied externally) and a parallel consumer.

Parameters:
n, 4, data word width in bits (n >= 2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-low reset
sin  input  1  serial data in; line idles high
sin_vld  input  1  bit strobe; sin is sampled only on cycles where sin_vld=1
pout  output  n  received data word
pout_vld  output  1  pout holds an undelivered word
pout_rdy  input  1  consumer accepts pout this cycle when pout_vld=1
frm_err  output  1  one-cycle pulse: stop bit sampled as 0, frame dropped
ovf  output  1  one-cycle pulse: good frame completed while buffer full, frame dropped

Behaviour:
Clock and reset:
- One clock, clk.
- Reset rst is asynchronous, active-low.
- Reset values: state=IDLE, bit counter=0, shift register=0, pout=0, pout_vld=0, frm_err=0, ovf=0.
- Reset mid-frame discards the partial frame and any buffered word.

Bit sampling:
- All sampling is qualified by sin_vld. Cycles with sin_vld=0 change nothing, except pout_vld clearing on pout_rdy and pulse outputs returning to 0.
- Gaps of any length between strobes are legal.

States:
- IDLE: sin_vld && sin==0 -> DATA, counter <= 0. sin==1 stays in IDLE.
- DATA: on each strobe, shift register <= {sin, shreg[n-1:1]} (first data bit ends in bit 0) and counter++. The strobe with counter==n-1 moves to STOP.
- STOP, on a strobe:
  - sin==1: good frame. If the buffer is free (pout_vld==0, or pout_vld && pout_rdy this cycle), pout <= assembled word and pout_vld <= 1 next cycle. Otherwise ovf=1 for one cycle, and pout/pout_vld are unchanged.
  - sin==0: frm_err=1 for one cycle, word discarded.
  - Either case -> IDLE.
  - The next start bit is accepted on the strobe immediately after the stop strobe.

Latency and timing:
- pout_vld rises on the clock edge that samples the stop bit, so it is visible the cycle after the stop strobe.
- frm_err and ovf are registered with the same timing.

Output handshake:
- While pout_vld && !pout_rdy, pout is held stable.
- pout_rdy with no load that cycle: pout_vld -> 0 and pout retains its value.
- Consume and load in the same cycle: pout takes the new word and pout_vld stays 1; ovf is not raised.
- pout_rdy while pout_vld=0 is ignored.

Counter and error rules:
- Counter width is $clog2(n). The counter is never compared beyond n-1.
- No break detection: a stop bit of 0 is always a frame error.
- frm_err and ovf are never asserted together.

Decomposition:
- Shared package rx_pkg: state encoding localparams RX_IDLE=2'd0, RX_DATA=2'd1, RX_STOP=2'd2. The remaining encoding is unused and recovers to RX_IDLE.
- One sub-module: rx_out_buf, the n-bit one-entry valid/ready holding register with load/consume/overflow logic. The top holds the FSM, counter and shift register.

Test Plan (n=4):
- Basic frame: sin_vld every cycle, sin = 0, 1,0,1,1, 1; pout_rdy=1 -> pout=4'hD and pout_vld=1 exactly one cycle after the stop strobe, then pout_vld=0.
- Gapped strobes: same frame with 3 idle cycles (sin_vld=0, sin toggling) between every bit -> pout=4'hD, no errors, state unaffected during gaps.
- Frame error: bits 0, 0,0,1,1, stop 0 -> frm_err pulses one cycle, pout_vld stays 0. The next frame 0,1,1,1,1,1 yields pout=4'hF.
- Overflow and hold: pout_rdy=0; send 4'h3 then 4'hA -> first frame gives pout=4'h3, pout_vld=1. Second frame gives ovf one-cycle pulse with pout still 4'h3. Asserting pout_rdy then gives pout_vld=0.
- Simultaneous consume/load: pout holds 4'h5, pout_rdy=1 on the cycle the 4'h9 stop bit is sampled -> next cycle pout=4'h9, pout_vld=1, ovf=0.
- Reset mid-frame: assert rst after 2 data bits -> all outputs 0 immediately (async). After release, a full frame 4'h6 is received correctly.
